// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: FSM states, store size
// encodings and the grant kind used for round-robin bookkeeping.
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_WORD   = 2'd0,
    SZ_BYTE   = 2'd1,
    SZ_HALF   = 2'd2,
    SZ_TRIPLE = 2'd3
  } size_t;

  typedef enum logic {
    KIND_LOAD  = 1'b0,
    KIND_STORE = 1'b1
  } kind_t;

  // Bit positions of the two requesters in the arbiter request/grant vectors.
  localparam int GNT_LD = 0;
  localparam int GNT_ST = 1;

endpackage

// File: rtl/dmem_port_arbiter_rr_arb2.sv
// Two-way round-robin selector. A lone requester always wins; on a tie the
// requester that did not win last time is chosen. Purely combinational.
module dmem_rr_arb2
  import dmem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // One-hot grant; last=1 means the store side won previously.
  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == KIND_STORE) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates a load unit and a retired-store queue onto a single data-memory
// port. One transaction is in flight at a time; a watchdog counter aborts a
// transaction the memory never acknowledges.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no transaction; at most one requester is offered ready
// BUSY  | command held on dm_* until dm_ack or watchdog expiry
// RESP  | single cycle presenting ld_resp_valid or st_done
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_req_valid,
  output logic             ld_req_ready,
  input  logic [31:0]      ld_req_addr,
  input  logic [TAG_W-1:0] ld_req_tag,
  input  logic             st_req_valid,
  output logic             st_req_ready,
  input  logic [31:0]      st_req_addr,
  input  logic [31:0]      st_req_data,
  input  logic [1:0]       st_req_size,
  input  logic             flush,
  output logic             ld_resp_valid,
  output logic [31:0]      ld_resp_data,
  output logic [TAG_W-1:0] ld_resp_tag,
  output logic             st_done,
  output logic             dm_req,
  output logic             dm_write,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_wdata,
  output logic [1:0]       dm_size,
  input  logic             dm_ack,
  input  logic [31:0]      dm_rdata,
  output logic             timeout_err
);

  // Counter value at which the final unacknowledged BUSY cycle is reached.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t           state_q, state_d;
  kind_t            kind_q;
  kind_t            last_grant_q;
  logic [31:0]      addr_q;
  logic [31:0]      data_q;
  size_t            size_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      rdata_q;
  logic             killed_q;
  logic [15:0]      cnt_q;
  logic             timeout_err_q;

  logic [1:0] grant;
  logic       idle, busy, resp;
  logic       ld_acc, st_acc;
  logic       tmo_hit;

  assign idle = (state_q == ST_IDLE);
  assign busy = (state_q == ST_BUSY);
  assign resp = (state_q == ST_RESP);

  // Arbitration ignores flush so the store-side ready never depends on it;
  // a flushed load simply loses its ready for that cycle.
  dmem_rr_arb2 u_arb (
    .req   ({st_req_valid, ld_req_valid}),
    .last  (last_grant_q),
    .grant (grant)
  );

  assign ld_req_ready = idle & grant[GNT_LD] & ~flush;
  assign st_req_ready = idle & grant[GNT_ST];
  assign ld_acc       = ld_req_valid & ld_req_ready;
  assign st_acc       = st_req_valid & st_req_ready;
  assign tmo_hit      = busy & ~dm_ack & (cnt_q == TMO_LAST);
  assign timeout_err  = timeout_err_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; dm_ack only matters in BUSY.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (ld_acc || st_acc) state_d = ST_BUSY;
      ST_BUSY: begin
        if (dm_ack)       state_d = ST_RESP;
        else if (tmo_hit) state_d = ST_IDLE;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode; everything is forced to zero outside its owning state.
  always_comb begin
    dm_req        = 1'b0;
    dm_write      = 1'b0;
    dm_addr       = 32'd0;
    dm_wdata      = 32'd0;
    dm_size       = 2'd0;
    ld_resp_valid = 1'b0;
    ld_resp_data  = 32'd0;
    ld_resp_tag   = '0;
    st_done       = 1'b0;
    unique case (state_q)
      ST_BUSY: begin
        dm_req = 1'b1;
        if (kind_q == KIND_STORE) begin
          dm_write = 1'b1;
          dm_addr  = addr_q;
          dm_wdata = data_q;
          dm_size  = size_q;
        end else begin
          dm_addr  = {addr_q[31:2], 2'b00};
        end
      end
      ST_RESP: begin
        if (kind_q == KIND_STORE) begin
          st_done = 1'b1;
        end else if (!killed_q && !flush) begin
          // A flush landing in the response cycle itself also squashes it.
          ld_resp_valid = 1'b1;
          ld_resp_data  = rdata_q;
          ld_resp_tag   = tag_q;
        end
      end
      default: ;
    endcase
  end

  // Capture the accepted request and remember who won for round-robin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_q       <= KIND_LOAD;
      last_grant_q <= KIND_LOAD;
      addr_q       <= 32'd0;
      data_q       <= 32'd0;
      size_q       <= SZ_WORD;
      tag_q        <= '0;
    end else if (ld_acc) begin
      kind_q       <= KIND_LOAD;
      last_grant_q <= KIND_LOAD;
      addr_q       <= ld_req_addr;
      data_q       <= 32'd0;
      size_q       <= SZ_WORD;
      tag_q        <= ld_req_tag;
    end else if (st_acc) begin
      kind_q       <= KIND_STORE;
      last_grant_q <= KIND_STORE;
      addr_q       <= st_req_addr;
      data_q       <= st_req_data;
      size_q       <= size_t'(st_req_size);
      tag_q        <= '0;
    end
  end

  // Load read data is latched on the acknowledging cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  rdata_q <= 32'd0;
    else if (busy && dm_ack && kind_q == KIND_LOAD) rdata_q <= dm_rdata;
  end

  // Kill flag: cleared per transaction, set by any flush while a load is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           killed_q <= 1'b0;
    else if (ld_acc || st_acc)                            killed_q <= 1'b0;
    else if ((busy || resp) && flush && kind_q == KIND_LOAD) killed_q <= 1'b1;
  end

  // Watchdog: counts BUSY cycles that pass without an acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt_q <= 16'd0;
    else if (ld_acc || st_acc) cnt_q <= 16'd0;
    else if (busy && !dm_ack)  cnt_q <= cnt_q + 16'd1;
  end

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       timeout_err_q <= 1'b0;
    else if (tmo_hit) timeout_err_q <= 1'b1;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: a table of single transactions plus
// hand-written sequences for arbitration ties, flush, watchdog and reset.
module tb_dmem_port_arbiter;

  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ld_req_valid, ld_req_ready;
  logic [31:0]      ld_req_addr;
  logic [TAG_W-1:0] ld_req_tag;
  logic             st_req_valid, st_req_ready;
  logic [31:0]      st_req_addr, st_req_data;
  logic [1:0]       st_req_size;
  logic             flush;
  logic             ld_resp_valid;
  logic [31:0]      ld_resp_data;
  logic [TAG_W-1:0] ld_resp_tag;
  logic             st_done;
  logic             dm_req, dm_write;
  logic [31:0]      dm_addr, dm_wdata;
  logic [1:0]       dm_size;
  logic             dm_ack;
  logic [31:0]      dm_rdata;
  logic             timeout_err;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready),
    .ld_req_addr(ld_req_addr), .ld_req_tag(ld_req_tag),
    .st_req_valid(st_req_valid), .st_req_ready(st_req_ready),
    .st_req_addr(st_req_addr), .st_req_data(st_req_data), .st_req_size(st_req_size),
    .flush(flush),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data), .ld_resp_tag(ld_resp_tag),
    .st_done(st_done),
    .dm_req(dm_req), .dm_write(dm_write), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_size(dm_size),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .timeout_err(timeout_err)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        is_st;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [3:0]  tag;
    int          delay;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [1:0]  exp_size;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts and ends just after a rising edge with the DUT idle.
  task automatic run_vec(input vec_t v, input string nm);
    if (v.is_st) begin
      st_req_valid = 1'b1; st_req_addr = v.addr; st_req_data = v.wdata; st_req_size = v.size;
    end else begin
      ld_req_valid = 1'b1; ld_req_addr = v.addr; ld_req_tag = v.tag;
    end
    @(negedge clk);
    chk({nm, ".ready"}, v.is_st ? st_req_ready : ld_req_ready, 32'd1);
    chk({nm, ".other_ready"}, v.is_st ? ld_req_ready : st_req_ready, 32'd0);
    tick();
    ld_req_valid = 1'b0;
    st_req_valid = 1'b0;
    for (int c = 0; c <= v.delay; c++) begin
      @(negedge clk);
      chk($sformatf("%s.dm_req[%0d]", nm, c), dm_req, 32'd1);
      chk($sformatf("%s.dm_write[%0d]", nm, c), dm_write, v.is_st);
      chk($sformatf("%s.dm_addr[%0d]", nm, c), dm_addr, v.exp_addr);
      chk($sformatf("%s.dm_size[%0d]", nm, c), dm_size, v.exp_size);
      chk($sformatf("%s.dm_wdata[%0d]", nm, c), dm_wdata, v.is_st ? v.wdata : 32'd0);
      chk($sformatf("%s.no_resp[%0d]", nm, c), {ld_resp_valid, st_done}, 32'd0);
      if (c == v.delay) begin
        dm_ack = 1'b1;
        dm_rdata = v.rdata;
      end else begin
        tick();
      end
    end
    tick();
    dm_ack = 1'b0;
    dm_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk({nm, ".st_done"}, st_done, v.is_st);
    chk({nm, ".ld_resp_valid"}, ld_resp_valid, !v.is_st);
    chk({nm, ".dm_req_resp"}, dm_req, 32'd0);
    if (!v.is_st) begin
      chk({nm, ".ld_resp_data"}, ld_resp_data, v.rdata);
      chk({nm, ".ld_resp_tag"}, ld_resp_tag, v.tag);
    end
    tick();
    @(negedge clk);
    chk({nm, ".after_resp"}, {ld_resp_valid, st_done, dm_req}, 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic exp_st;
    int   st_cnt, ld_cnt, nseen, resp_seen;

    //         is_st  addr           wdata          size tag  dly rdata          exp_addr       exp_size
    vecs[0] = '{1'b0, 32'h0000_1003, 32'h0,         2'd0, 4'd5, 0, 32'hAABB_CCDD, 32'h0000_1000, 2'd0};
    vecs[1] = '{1'b1, 32'h0000_2001, 32'h0000_00EE, 2'd1, 4'd0, 4, 32'h0,         32'h0000_2001, 2'd1};
    vecs[2] = '{1'b1, 32'h3000_0002, 32'h0000_BEEF, 2'd2, 4'd0, 1, 32'h0,         32'h3000_0002, 2'd2};
    vecs[3] = '{1'b0, 32'h4000_0006, 32'h0,         2'd0, 4'hA, 2, 32'h1234_5678, 32'h4000_0004, 2'd0};
    vecs[4] = '{1'b1, 32'h0000_0105, 32'h00CC_BBAA, 2'd3, 4'd0, 0, 32'h0,         32'h0000_0105, 2'd3};
    vecs[5] = '{1'b1, 32'h0000_0200, 32'hCAFE_F00D, 2'd0, 4'd0, 7, 32'h0,         32'h0000_0200, 2'd0};

    ld_req_valid = 0; ld_req_addr = 0; ld_req_tag = 0;
    st_req_valid = 0; st_req_addr = 0; st_req_data = 0; st_req_size = 0;
    flush = 0; dm_ack = 0; dm_rdata = 0;

    // Reset state
    #2;
    chk("rst.dm_bus", {dm_req, dm_write, dm_size}, 32'd0);
    chk("rst.dm_addr", dm_addr, 32'd0);
    chk("rst.timeout_err", timeout_err, 32'd0);
    #20 rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("idle.readies", {ld_req_ready, st_req_ready}, 32'd0);
    chk("idle.resp", {ld_resp_valid, st_done}, 32'd0);
    tick();

    // Both requesters valid from reset: store wins first, then alternation
    st_req_valid = 1; st_req_addr = 32'h500; st_req_data = 32'h11; st_req_size = 2'd0;
    ld_req_valid = 1; ld_req_addr = 32'h600; ld_req_tag = 4'd3;
    st_cnt = 0; ld_cnt = 0;
    for (int g = 0; g < 4; g++) begin
      exp_st = (g % 2 == 0);
      @(negedge clk);
      chk($sformatf("tie%0d.st_ready", g), st_req_ready, exp_st);
      chk($sformatf("tie%0d.ld_ready", g), ld_req_ready, !exp_st);
      tick();
      @(negedge clk);
      chk($sformatf("tie%0d.dm_write", g), dm_write, exp_st);
      chk($sformatf("tie%0d.busy_readies", g), {ld_req_ready, st_req_ready}, 32'd0);
      dm_ack = 1'b1;
      dm_rdata = 32'h7000 + g;
      tick();
      dm_ack = 1'b0;
      @(negedge clk);
      chk($sformatf("tie%0d.st_done", g), st_done, exp_st);
      chk($sformatf("tie%0d.ld_resp_valid", g), ld_resp_valid, !exp_st);
      if (st_done) st_cnt++;
      if (ld_resp_valid) ld_cnt++;
      tick();
    end
    ld_req_valid = 0;
    st_req_valid = 0;
    chk("tie.st_count", st_cnt, 32'd2);
    chk("tie.ld_count", ld_cnt, 32'd2);
    tick();

    // Single-transaction table
    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Flush masks only the load ready; valids drop before the edge so nothing is accepted
    ld_req_valid = 1; ld_req_addr = 32'h700; flush = 1;
    @(negedge clk);
    chk("flush.ld_ready", ld_req_ready, 32'd0);
    ld_req_valid = 0;
    st_req_valid = 1; st_req_addr = 32'h704;
    #1;
    chk("flush.st_ready", st_req_ready, 32'd1);
    st_req_valid = 0;
    flush = 0;
    tick();

    // Load killed by flush in its second BUSY cycle still completes the access
    ld_req_valid = 1; ld_req_addr = 32'h800; ld_req_tag = 4'd7;
    @(negedge clk);
    chk("kill.ready", ld_req_ready, 32'd1);
    tick();
    ld_req_valid = 0;
    @(negedge clk);
    chk("kill.busy1", dm_req, 32'd1);
    tick();
    flush = 1;
    @(negedge clk);
    chk("kill.busy2", dm_req, 32'd1);
    dm_ack = 1; dm_rdata = 32'h9999_0000;
    tick();
    flush = 0; dm_ack = 0;
    @(negedge clk);
    chk("kill.no_resp", ld_resp_valid, 32'd0);
    tick();
    @(negedge clk);
    chk("kill.idle", {ld_resp_valid, dm_req}, 32'd0);
    tick();
    run_vec(vecs[0], "after_kill");

    // Watchdog: no ack at all
    ld_req_valid = 1; ld_req_addr = 32'h900; ld_req_tag = 4'd2;
    @(negedge clk);
    chk("tmo.ready", ld_req_ready, 32'd1);
    tick();
    ld_req_valid = 0;
    nseen = 0; resp_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ld_resp_valid || st_done) resp_seen++;
      if (!dm_req) break;
      nseen++;
      tick();
    end
    chk("tmo.busy_cycles", nseen, TIMEOUT);
    chk("tmo.err", timeout_err, 32'd1);
    chk("tmo.no_resp", resp_seen, 32'd0);
    repeat (3) tick();
    @(negedge clk);
    chk("tmo.err_sticky", timeout_err, 32'd1);
    chk("tmo.no_resp_later", {ld_resp_valid, st_done}, 32'd0);
    tick();
    run_vec(vecs[4], "after_tmo");
    chk("tmo.err_still", timeout_err, 32'd1);
    rst_n = 0;
    #1;
    chk("tmo.err_cleared", timeout_err, 32'd0);
    #1 rst_n = 1;
    tick();

    // Reset in the middle of a store
    st_req_valid = 1; st_req_addr = 32'hA00; st_req_data = 32'h77; st_req_size = 2'd0;
    @(negedge clk);
    chk("rstbusy.ready", st_req_ready, 32'd1);
    tick();
    st_req_valid = 0;
    @(negedge clk);
    chk("rstbusy.dm_req", dm_req, 32'd1);
    #1 rst_n = 0;
    #1;
    chk("rstbusy.dm_ctrl", {dm_req, dm_write, dm_size}, 32'd0);
    chk("rstbusy.dm_addr", dm_addr, 32'd0);
    chk("rstbusy.dm_wdata", dm_wdata, 32'd0);
    @(posedge clk);
    #2 rst_n = 1;
    dm_ack = 1;
    resp_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ld_resp_valid || st_done || dm_req) resp_seen++;
      dm_ack = 0;
      tick();
    end
    chk("rstbusy.no_resp", resp_seen, 32'd0);
    run_vec(vecs[3], "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
